// File: rtl/lcd_rx_monitor.sv
// Receive-side monitor for a DE-mode RGB565 LCD link: rebuilds pixel coordinates
// from the data-enable timing, checks line/frame geometry and sums each frame.
module lcd_rx_monitor #(
    parameter int H_ACTIVE  = 480,
    parameter int V_ACTIVE  = 272,
    parameter int V_GAP_MIN = 1024,
    parameter int GAP_W     = 11
) (
    input  logic        PixelClk,
    input  logic        Reset,
    input  logic        LCD_DEN,
    input  logic [4:0]  LCD_R,
    input  logic [5:0]  LCD_G,
    input  logic [4:0]  LCD_B,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_count,
    output logic        line_len_err,
    output logic        line_cnt_err,
    output logic        locked
);

    localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(V_GAP_MIN);
    localparam logic [8:0]       X_MAX    = 9'(H_ACTIVE - 1);
    localparam logic [8:0]       Y_MAX    = 9'(V_ACTIVE - 1);
    localparam logic [9:0]       LINE_LEN = 10'(H_ACTIVE);
    localparam logic [9:0]       LINE_CNT = 10'(V_ACTIVE);

    typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, HBLANK} state_t;

    state_t           state;
    logic [GAP_W-1:0] gap;
    logic [9:0]       line_px;
    logic [9:0]       lines;
    logic [15:0]      sum;

    logic [15:0]      rgb;
    logic [GAP_W-1:0] gap_inc;
    logic [9:0]       px_inc;
    logic [9:0]       lines_inc;

    assign rgb       = {LCD_R, LCD_G, LCD_B};
    assign gap_inc   = (&gap)     ? gap     : gap + GAP_W'(1);
    assign px_inc    = (&line_px) ? line_px : line_px + 10'd1;
    assign lines_inc = (&lines)   ? lines   : lines + 10'd1;

    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            state        <= SYNC;
            gap          <= '0;
            line_px      <= '0;
            lines        <= '0;
            sum          <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_data     <= '0;
            frame_done   <= 1'b0;
            frame_sum    <= '0;
            frame_count  <= '0;
            line_len_err <= 1'b0;
            line_cnt_err <= 1'b0;
            locked       <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                // Wait for a DE-low run long enough to be vertical blanking.
                SYNC: begin
                    if (LCD_DEN) begin
                        gap <= '0;
                    end else begin
                        gap <= gap_inc;
                        if (gap_inc >= GAP_MIN) begin
                            locked <= 1'b1;
                            state  <= VBLANK;
                        end
                    end
                end
                VBLANK: begin
                    if (LCD_DEN) begin
                        state     <= ACTIVE;
                        pix_valid <= 1'b1;
                        pix_x     <= '0;
                        pix_y     <= '0;
                        pix_data  <= rgb;
                        line_px   <= 10'd1;
                        lines     <= '0;
                        sum       <= rgb;
                    end
                end
                ACTIVE: begin
                    if (LCD_DEN) begin
                        pix_valid <= 1'b1;
                        pix_x     <= (pix_x >= X_MAX) ? X_MAX : pix_x + 9'd1;
                        pix_data  <= rgb;
                        line_px   <= px_inc;
                        sum       <= sum + rgb;
                    end else begin
                        state        <= HBLANK;
                        gap          <= GAP_W'(1);
                        line_len_err <= line_len_err | (line_px != LINE_LEN);
                        lines        <= lines_inc;
                    end
                end
                // A rising DE always wins over the gap reaching the vertical threshold.
                HBLANK: begin
                    if (LCD_DEN) begin
                        state     <= ACTIVE;
                        pix_valid <= 1'b1;
                        pix_x     <= '0;
                        pix_y     <= (pix_y >= Y_MAX) ? Y_MAX : pix_y + 9'd1;
                        pix_data  <= rgb;
                        line_px   <= 10'd1;
                        sum       <= sum + rgb;
                    end else begin
                        gap <= gap_inc;
                        if (gap_inc >= GAP_MIN) begin
                            state        <= VBLANK;
                            frame_done   <= 1'b1;
                            frame_sum    <= sum;
                            frame_count  <= frame_count + 16'd1;
                            line_cnt_err <= line_cnt_err | (lines != LINE_CNT);
                            lines        <= '0;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Bench for lcd_rx_monitor: frames are described as line lengths and gaps, the
// expected pixel stream and frame results are derived from that description.
module tb_lcd_rx_monitor;

    localparam int H    = 32;
    localparam int V    = 64;
    localparam int GMIN = 100;
    localparam int GW   = 7;
    localparam int HB   = 6;
    localparam int VB   = 150;

    logic        PixelClk = 1'b0;
    logic        Reset;
    logic        LCD_DEN;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [15:0] frame_count;
    logic        line_len_err;
    logic        line_cnt_err;
    logic        locked;

    lcd_rx_monitor #(
        .H_ACTIVE(H), .V_ACTIVE(V), .V_GAP_MIN(GMIN), .GAP_W(GW)
    ) dut (
        .PixelClk(PixelClk), .Reset(Reset), .LCD_DEN(LCD_DEN),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_done(frame_done), .frame_sum(frame_sum), .frame_count(frame_count),
        .line_len_err(line_len_err), .line_cnt_err(line_cnt_err), .locked(locked)
    );

    always #5 PixelClk = ~PixelClk;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] d;
    } pix_t;

    pix_t        expq[$];
    pix_t        mon_e;
    int          fl_len[$];
    int          fl_gap[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [15:0] seen_sum = '0;
    int          exp_count = 0;
    logic [15:0] exp_sum = '0;
    bit          exp_len_err = 0;
    bit          exp_cnt_err = 0;

    // Scoreboard: every strobe must match the next expected pixel.
    always @(negedge PixelClk) begin
        if (pix_valid === 1'b1) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d data=%h, want no strobe", pix_x, pix_y, pix_data);
            end else begin
                mon_e = expq.pop_front();
                if (pix_x !== 9'(mon_e.x) || pix_y !== 9'(mon_e.y) || pix_data !== mon_e.d) begin
                    bad++;
                    $display("FAIL pixel: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                             pix_x, pix_y, pix_data, mon_e.x, mon_e.y, mon_e.d);
                end
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            seen_sum = frame_sum;
        end
    end

    task automatic drive(input bit de, input logic [15:0] d);
        LCD_DEN = de;
        {LCD_R, LCD_G, LCD_B} = d;
        @(posedge PixelClk);
        #1;
    endtask

    function automatic logic [15:0] pix_val(input int mode, input int i, input int l);
        logic [31:0] r;
        case (mode)
            0: return 16'h0001;
            1: begin r = $urandom; return r[15:0]; end
            default: return {5'(i), 6'(l), 5'd0};
        endcase
    endfunction

    task automatic set_nominal();
        fl_len.delete();
        fl_gap.delete();
        for (int l = 0; l < V; l++) begin
            fl_len.push_back(H);
            fl_gap.push_back(HB);
        end
        fl_gap[V-1] = VB;
    endtask

    // Drives the frame in fl_len/fl_gap; when captured, records what the monitor must report.
    task automatic send_frame(input int mode, input bit capture);
        logic [15:0] s;
        logic [15:0] d;
        bit          le;
        pix_t        e;
        s  = '0;
        le = 0;
        for (int l = 0; l < fl_len.size(); l++) begin
            if (fl_len[l] != H) le = 1;
            for (int i = 0; i < fl_len[l]; i++) begin
                d = pix_val(mode, i, l);
                if (capture) begin
                    e.x = (i < H) ? i : H - 1;
                    e.y = (l < V) ? l : V - 1;
                    e.d = d;
                    expq.push_back(e);
                end
                s = s + d;
                drive(1'b1, d);
            end
            for (int g = 0; g < fl_gap[l]; g++) drive(1'b0, 16'h0);
        end
        if (capture) begin
            exp_count++;
            exp_sum = s;
            exp_len_err |= le;
            exp_cnt_err |= (fl_len.size() != V);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) drive(1'b0, 16'h0);
        total++;
        if ({pix_valid, pix_x, pix_y, pix_data, frame_done, frame_sum, frame_count,
             line_len_err, line_cnt_err, locked} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d data=%h sum=%h count=%0d errs=%b%b locked=%b, want all 0",
                     pix_valid, pix_x, pix_y, pix_data, frame_sum, frame_count, line_len_err, line_cnt_err, locked);
        end
        Reset = 1'b0;
        repeat (GMIN - 1) drive(1'b0, 16'h0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_early: got locked=%b want 0", locked);
        end
        drive(1'b0, 16'h0);
        total++;
        if (locked !== 1'b1 || pix_valid !== 1'b0 || frame_count !== 16'd0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL lock: got locked=%b valid=%b count=%0d done=%b want 1 0 0 0",
                     locked, pix_valid, frame_count, frame_done);
        end
    endtask

    task automatic test_nominal();
        int d0;
        for (int m = 0; m < 2; m++) begin
            d0 = done_cnt;
            set_nominal();
            send_frame(m, 1);
            @(negedge PixelClk); #1;
            total++;
            if (done_cnt !== d0 + 1) begin bad++; $display("FAIL nominal_done: got %0d pulses want 1", done_cnt - d0); end
            total++;
            if (seen_sum !== exp_sum) begin bad++; $display("FAIL nominal_sum: got %h want %h", seen_sum, exp_sum); end
            total++;
            if ({frame_count, line_len_err, line_cnt_err} !== {16'(exp_count), exp_len_err, exp_cnt_err}) begin
                bad++;
                $display("FAIL nominal_status: got count=%0d errs=%b%b want count=%0d errs=%b%b",
                         frame_count, line_len_err, line_cnt_err, exp_count, exp_len_err, exp_cnt_err);
            end
            total++;
            if (expq.size() != 0) begin bad++; $display("FAIL nominal_missing: got %0d pixels unseen want 0", expq.size()); end
        end
    endtask

    task automatic test_gap_boundary();
        int d0;
        d0 = done_cnt;
        set_nominal();
        fl_gap[5]   = GMIN - 1;
        fl_gap[V-1] = GMIN;
        send_frame(1, 1);
        @(negedge PixelClk); #1;
        total++;
        if (done_cnt !== d0 + 1) begin bad++; $display("FAIL boundary_done: got %0d pulses want 1", done_cnt - d0); end
        total++;
        if (seen_sum !== exp_sum) begin bad++; $display("FAIL boundary_sum: got %h want %h", seen_sum, exp_sum); end
        total++;
        if ({frame_count, line_len_err, line_cnt_err} !== {16'(exp_count), exp_len_err, exp_cnt_err}) begin
            bad++;
            $display("FAIL boundary_status: got count=%0d errs=%b%b want count=%0d errs=%b%b",
                     frame_count, line_len_err, line_cnt_err, exp_count, exp_len_err, exp_cnt_err);
        end
    endtask

    task automatic test_ramp();
        set_nominal();
        send_frame(2, 1);
        @(negedge PixelClk); #1;
        total++;
        if (pix_x !== 9'd31 || pix_y !== 9'd63 || pix_data !== 16'hFFE0) begin
            bad++;
            $display("FAIL ramp_corner: got (%0d,%0d,%h) want (31,63,ffe0)", pix_x, pix_y, pix_data);
        end
        total++;
        if (seen_sum !== exp_sum) begin bad++; $display("FAIL ramp_sum: got %h want %h", seen_sum, exp_sum); end
    endtask

    task automatic test_short_line();
        total++;
        if (line_len_err !== 1'b0) begin bad++; $display("FAIL short_line_pre: got %b want 0", line_len_err); end
        for (int f = 0; f < 2; f++) begin
            set_nominal();
            if (f == 0) fl_len[10] = H - 1;
            send_frame(1, 1);
            @(negedge PixelClk); #1;
            total++;
            if ({frame_count, line_len_err, line_cnt_err} !== {16'(exp_count), exp_len_err, exp_cnt_err}) begin
                bad++;
                $display("FAIL short_line_status: got count=%0d errs=%b%b want count=%0d errs=%b%b",
                         frame_count, line_len_err, line_cnt_err, exp_count, exp_len_err, exp_cnt_err);
            end
            total++;
            if (seen_sum !== exp_sum) begin bad++; $display("FAIL short_line_sum: got %h want %h", seen_sum, exp_sum); end
        end
    endtask

    task automatic test_short_frame();
        int d0;
        d0 = done_cnt;
        set_nominal();
        void'(fl_len.pop_back());
        void'(fl_gap.pop_back());
        fl_gap[V-2] = VB;
        send_frame(1, 1);
        @(negedge PixelClk); #1;
        total++;
        if (done_cnt !== d0 + 1) begin bad++; $display("FAIL short_frame_done: got %0d pulses want 1", done_cnt - d0); end
        total++;
        if ({frame_count, line_len_err, line_cnt_err} !== {16'(exp_count), exp_len_err, exp_cnt_err}) begin
            bad++;
            $display("FAIL short_frame_status: got count=%0d errs=%b%b want count=%0d errs=%b%b",
                     frame_count, line_len_err, line_cnt_err, exp_count, exp_len_err, exp_cnt_err);
        end
    endtask

    task automatic test_reset_mid();
        int   d0;
        pix_t e;
        logic [15:0] d;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < ((l < 3) ? H : 11); i++) begin
                d = pix_val(1, i, l);
                e.x = i; e.y = l; e.d = d;
                expq.push_back(e);
                drive(1'b1, d);
            end
            if (l < 3) repeat (HB) drive(1'b0, 16'h0);
        end
        d0 = done_cnt;
        Reset = 1'b1;
        drive(1'b1, 16'h1234);
        Reset = 1'b0;
        exp_count = 0; exp_len_err = 0; exp_cnt_err = 0;
        total++;
        if ({pix_valid, pix_x, pix_y, pix_data, frame_done, frame_sum, frame_count,
             line_len_err, line_cnt_err, locked} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got valid=%b x=%0d y=%0d data=%h count=%0d locked=%b, want all 0",
                     pix_valid, pix_x, pix_y, pix_data, frame_count, locked);
        end
        // Rest of the aborted frame: nothing may be emitted until a fresh vertical gap.
        fl_len.delete(); fl_gap.delete();
        fl_len.push_back(H - 12); fl_gap.push_back(HB);
        for (int l = 4; l < V; l++) begin fl_len.push_back(H); fl_gap.push_back(HB); end
        fl_gap[fl_gap.size()-1] = VB;
        send_frame(1, 0);
        @(negedge PixelClk); #1;
        total++;
        if (done_cnt !== d0 || frame_count !== 16'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_abort: got pulses=%0d count=%0d locked=%b want 0 0 1", done_cnt - d0, frame_count, locked);
        end
        set_nominal();
        send_frame(1, 1);
        @(negedge PixelClk); #1;
        total++;
        if ({frame_count, line_len_err, line_cnt_err} !== {16'(exp_count), exp_len_err, exp_cnt_err} || seen_sum !== exp_sum) begin
            bad++;
            $display("FAIL reset_mid_resume: got count=%0d errs=%b%b sum=%h want count=%0d errs=%b%b sum=%h",
                     frame_count, line_len_err, line_cnt_err, seen_sum, exp_count, exp_len_err, exp_cnt_err, exp_sum);
        end
    endtask

    task automatic test_de_stuck();
        set_nominal();
        fl_len[0] = 100;
        send_frame(1, 1);
        @(negedge PixelClk); #1;
        total++;
        if ({frame_count, line_len_err, line_cnt_err, locked} !== {16'(exp_count), exp_len_err, exp_cnt_err, 1'b1}) begin
            bad++;
            $display("FAIL de_stuck_status: got count=%0d errs=%b%b locked=%b want count=%0d errs=%b%b locked=1",
                     frame_count, line_len_err, line_cnt_err, locked, exp_count, exp_len_err, exp_cnt_err);
        end
        total++;
        if (expq.size() != 0) begin bad++; $display("FAIL de_stuck_missing: got %0d pixels unseen want 0", expq.size()); end
    endtask

    task automatic test_de_toggle();
        int d0;
        d0 = done_cnt;
        fl_len.delete(); fl_gap.delete();
        for (int l = 0; l < 20; l++) begin fl_len.push_back(1); fl_gap.push_back(1); end
        fl_gap[19] = VB;
        send_frame(1, 1);
        @(negedge PixelClk); #1;
        total++;
        if (done_cnt !== d0 + 1) begin bad++; $display("FAIL toggle_done: got %0d pulses want 1", done_cnt - d0); end
        total++;
        if ({frame_count, line_len_err, line_cnt_err} !== {16'(exp_count), exp_len_err, exp_cnt_err} || seen_sum !== exp_sum) begin
            bad++;
            $display("FAIL toggle_status: got count=%0d errs=%b%b sum=%h want count=%0d errs=%b%b sum=%h",
                     frame_count, line_len_err, line_cnt_err, seen_sum, exp_count, exp_len_err, exp_cnt_err, exp_sum);
        end
    endtask

    task automatic test_random();
        int d0;
        int r;
        Reset = 1'b1;
        drive(1'b0, 16'h0);
        Reset = 1'b0;
        exp_count = 0; exp_len_err = 0; exp_cnt_err = 0;
        repeat (GMIN) drive(1'b0, 16'h0);
        for (int f = 0; f < 3; f++) begin
            d0 = done_cnt;
            fl_len.delete(); fl_gap.delete();
            for (int l = 0; l < V - 1 + int'($urandom_range(0, 2)); l++) begin
                r = $urandom_range(0, 19);
                fl_len.push_back((r == 0) ? H - 1 : (r == 1) ? H + 1 : H);
                fl_gap.push_back(($urandom_range(0, 7) == 0) ? GMIN - 1 : int'($urandom_range(1, 12)));
            end
            fl_gap[fl_gap.size()-1] = $urandom_range(GMIN, GMIN + 40);
            send_frame(1, 1);
            @(negedge PixelClk); #1;
            total++;
            if (done_cnt !== d0 + 1) begin bad++; $display("FAIL random_done: got %0d pulses want 1", done_cnt - d0); end
            total++;
            if ({frame_count, line_len_err, line_cnt_err} !== {16'(exp_count), exp_len_err, exp_cnt_err} || seen_sum !== exp_sum) begin
                bad++;
                $display("FAIL random_status: got count=%0d errs=%b%b sum=%h want count=%0d errs=%b%b sum=%h",
                         frame_count, line_len_err, line_cnt_err, seen_sum, exp_count, exp_len_err, exp_cnt_err, exp_sum);
            end
            total++;
            if (expq.size() != 0) begin bad++; $display("FAIL random_missing: got %0d pixels unseen want 0", expq.size()); end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        LCD_DEN = 1'b0;
        LCD_R   = '0;
        LCD_G   = '0;
        LCD_B   = '0;
        test_reset();
        test_nominal();
        test_gap_boundary();
        test_ramp();
        test_short_line();
        test_short_frame();
        test_reset_mid();
        test_de_stuck();
        test_de_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_rx_monitor.md
Name: lcd_rx_monitor

Overview:
- Receive-side counterpart of the DE-mode RGB565 LCD drive path. Samples LCD_DEN/R/G/B on the pixel clock and rebuilds pixel coordinates, emitting a pixel stream for framebuffer capture.
- Checks line length and line count against the panel geometry, and produces a per-frame checksum.
- Sits in loopback benches and on-board self-test, tapping the same wires the panel sees.

Parameters:
- H_ACTIVE, 480, active pixels per line (DE-high cycles).
- V_ACTIVE, 272, active lines per frame.
- V_GAP_MIN, 1024, DE-low cycles that mark vertical blanking. Must exceed the horizontal blank (51) and be below the vertical blank (20 lines × 531).
- GAP_W, 11, width of the saturating gap counter; 2^GAP_W-1 must be ≥ V_GAP_MIN.

Ports:
- PixelClk  in  1  pixel clock, 9 MHz nominal.
- Reset  in  1  synchronous, active-high.
- LCD_DEN  in  1  data enable from the LCD driver.
- LCD_R  in  5  red.
- LCD_G  in  6  green.
- LCD_B  in  5  blue.
- pix_valid  out  1  captured pixel strobe.
- pix_x  out  9  column of the current pixel, 0..H_ACTIVE-1.
- pix_y  out  9  row of the current pixel, 0..V_ACTIVE-1.
- pix_data  out  16  {R,G,B} RGB565.
- frame_done  out  1  one-cycle pulse at end of a checked frame.
- frame_sum  out  16  sum mod 2^16 of all pix_data in the last frame; valid from frame_done.
- frame_count  out  16  completed frames, wraps at 2^16.
- line_len_err  out  1  sticky: some line had a DE-high run ≠ H_ACTIVE.
- line_cnt_err  out  1  sticky: some frame had a line count ≠ V_ACTIVE.
- locked  out  1  high after the first vertical gap is seen.

Behaviour:
- One clock, PixelClk. Reset is synchronous and active-high.
- Reset values: all outputs 0; state SYNC; all counters 0.
- Inputs are sampled at each PixelClk rising edge. Outputs are registered, with 1-cycle latency: an edge sampling DEN=1 yields pix_valid=1 with that pixel's data in the following cycle.
- SYNC
  - Ignore DE and count consecutive DE-low cycles, saturating.
  - When gap reaches V_GAP_MIN: locked←1, go to VBLANK.
  - A DE-high sample clears gap and stays in SYNC; no pixels are emitted.
- VBLANK
  - DE=1 → ACTIVE, x=0, y=0, line_px=1, running sum cleared then seeded with this pixel.
- ACTIVE
  - Each DE=1 sample emits a pixel and increments x.
  - x saturates at H_ACTIVE-1 for output purposes. line_px keeps counting, saturating at 2^10-1.
  - DE=0 → HBLANK: gap=1, line_len_err |= (line_px ≠ H_ACTIVE), lines += 1.
- HBLANK
  - DE=0: gap += 1 (saturating).
  - DE=1 before V_GAP_MIN → ACTIVE with y+1 (y saturates at V_ACTIVE-1), x=0, line_px=1.
  - gap reaches V_GAP_MIN → end of frame, go to VBLANK:
    - frame_done pulses for 1 cycle.
    - frame_sum latches the running sum.
    - frame_count += 1.
    - line_cnt_err |= (lines ≠ V_ACTIVE).
    - lines reset to 0.
- A frame that starts before locked never produces frame_done.
- Sticky errors clear only on Reset.
- Checksum: 16-bit wrap-around addition of every emitted pix_data in the frame.
- pix_x, pix_y and pix_data hold their last values when pix_valid=0.
- DE held high indefinitely: x saturates, line_len_err sets at the eventual fall, no lock loss.
- Reset asserted mid-line or mid-frame: an immediate return to SYNC at the next edge. The partial frame is discarded, with no frame_done and no error update.
- DE toggling every cycle: each 1-cycle run is a line of length 1, which sets line_len_err. No vertical gap is declared.
- Simultaneous boundaries: when gap hits V_GAP_MIN on the same edge DE rises, DE wins. It is treated as a line start, and the frame is not closed.

Test Plan:
1. Reset, then DE low for 1024 cycles → locked=1 on the following cycle; all other outputs still 0.
2. Full 480×272 frame of constant pix 0x0001, standard timing (51 h-blank, 20×531 v-blank) → 130560 pix_valid pulses, last with x=479, y=271. frame_done pulses once with frame_sum=0xFE00 (130560 mod 65536) and frame_count=1; both error flags 0.
3. Line 10 shortened to 479 pixels, rest nominal → line_len_err=1 after line 10's falling DE; line_cnt_err=0; flag stays set through the next good frame.
4. Frame of 271 lines → frame_done pulses with line_cnt_err=1 and frame_count incremented.
5. Reset asserted at pixel (200,100) for 1 cycle → no frame_done and outputs 0. Pixel output resumes only after a ≥1024-cycle DE-low gap and the next frame's first DE.
6. Pixel ramp R=x[4:0], G=y[5:0], B=0 → pix_data at (31,63) equals 0xFFE0, and pix_x/pix_y match the ramp at every strobe.
